// File: rtl/fib_seq_gen.sv
// fib_seq_gen -- Fibonacci sequence source stage.
//
// A start pulse makes the block emit 0,1,1,2,3,5,... as N-bit words on a
// valid/ready stream. The stream stops after the largest term that fits in
// N bits, so every word it emits is a Fibonacci number. For N=4 the words
// are 0,1,2,3,5,8,13, with 1 appearing twice.
//
// Parameters
//   N          width of out_data
//   CW         width of term_cnt; it must hold the number of terms for N
//
// Ports
//   clk        clock; all state changes on its rising edge
//   rst        asynchronous, active-high reset
//   start      one-cycle request to begin a sequence; acted on only in IDLE or DONE
//   abort      return to IDLE; wins over start
//   out_ready  downstream accepts out_data this cycle
//   out_valid  out_data holds a valid term
//   out_data   current Fibonacci term
//   out_last   out_data is the last term that fits in N bits
//   busy       sequence in progress (RUN)
//   done       last term was accepted; held until start or abort
//   term_cnt   number of terms accepted since the last start
module fib_seq_gen #(
    parameter int N  = 4,
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [N-1:0]  out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] term_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    // out_data holds the current term a. b is the next term, one bit wider,
    // so that its top bit shows when the next term no longer fits in N bits.
    logic [N:0]   b;
    logic [N:0]   sum;
    logic         fire;

    assign fire = out_valid & out_ready;
    // a + b never overflows N+1 bits. The adder result is only used while
    // b[N] is 0, because the stream stops at the term whose successor overflows.
    assign sum  = {1'b0, out_data} + b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            term_cnt  <= '0;
            b         <= (N+1)'(1);
        end else if (abort) begin
            // term_cnt keeps its value, so the number of terms accepted
            // before the abort can still be read. The next start clears it.
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            b         <= (N+1)'(1);
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= RUN;
                        out_valid <= 1'b1;
                        out_data  <= '0;
                        out_last  <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        term_cnt  <= '0;
                        b         <= (N+1)'(1);
                    end
                end
                RUN: begin
                    // Without a handshake every output holds, so the data
                    // stays stable under backpressure. start is ignored here.
                    if (fire) begin
                        term_cnt <= term_cnt + CW'(1);
                        if (out_last) begin
                            state     <= DONE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            out_data <= b[N-1:0];
                            b        <= sum;
                            // The new b is the sum; its top bit flags the new
                            // current term as the last one that fits.
                            out_last <= sum[N];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_seq_gen.sv
module tb_fib_seq_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       abort = 1'b0;
    logic       out_ready = 1'b0;
    logic       start4 = 1'b0;
    logic       start8 = 1'b0;

    logic       v4, l4, b4, dn4;
    logic [3:0] d4;
    logic [5:0] c4;
    logic       v8, l8, b8, dn8;
    logic [7:0] d8;
    logic [5:0] c8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fib_seq_gen #(.N(4), .CW(6)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .abort(abort), .out_ready(out_ready),
        .out_valid(v4), .out_data(d4), .out_last(l4), .busy(b4), .done(dn4), .term_cnt(c4)
    );

    fib_seq_gen #(.N(8), .CW(6)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .abort(abort), .out_ready(out_ready),
        .out_valid(v8), .out_data(d8), .out_last(l8), .busy(b8), .done(dn8), .term_cnt(c8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] o_valid(input bit w8); return w8 ? 32'(v8)  : 32'(v4);  endfunction
    function automatic logic [31:0] o_data (input bit w8); return w8 ? 32'(d8)  : 32'(d4);  endfunction
    function automatic logic [31:0] o_last (input bit w8); return w8 ? 32'(l8)  : 32'(l4);  endfunction
    function automatic logic [31:0] o_busy (input bit w8); return w8 ? 32'(b8)  : 32'(b4);  endfunction
    function automatic logic [31:0] o_done (input bit w8); return w8 ? 32'(dn8) : 32'(dn4); endfunction
    function automatic logic [31:0] o_cnt  (input bit w8); return w8 ? 32'(c8)  : 32'(c4);  endfunction

    task automatic chk_all_zero(input bit w8, input string tag);
        chk({tag, "_valid"}, o_valid(w8), 0);
        chk({tag, "_data"},  o_data(w8),  0);
        chk({tag, "_last"},  o_last(w8),  0);
        chk({tag, "_busy"},  o_busy(w8),  0);
        chk({tag, "_done"},  o_done(w8),  0);
        chk({tag, "_cnt"},   o_cnt(w8),   0);
    endtask

    // mode: 0 ready held high, 1 ready toggles 1,0,1,..., 2 random ready plus stray starts
    // intr_kind: 0 none, 1 abort once intr_at terms are accepted, 2 async reset at that point
    task automatic run_stream(input bit w8, input int mode, input int intr_at, input int intr_kind);
        int q[$];
        int idx, cyc, n, w;
        bit rdy;
        w = w8 ? 8 : 4;
        // Reference: every Fibonacci number up to 2^w-1, in order
        q = {0, 1};
        while (q[q.size()-1] + q[q.size()-2] <= (1 << w) - 1)
            q.push_back(q[q.size()-1] + q[q.size()-2]);
        n = q.size();

        @(negedge clk);
        if (w8) start8 = 1'b1; else start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        start8 = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 400) begin
            chk("valid", o_valid(w8), 1);
            chk("data",  o_data(w8),  q[idx]);
            chk("last",  o_last(w8),  (idx == n - 1) ? 1 : 0);
            chk("busy",  o_busy(w8),  1);
            chk("done_run", o_done(w8), 0);
            chk("cnt_run",  o_cnt(w8),  idx);
            if (intr_kind == 1 && idx == intr_at) begin
                abort = 1'b1;
                out_ready = 1'b0;
                @(negedge clk);
                abort = 1'b0;
                chk("abort_valid", o_valid(w8), 0);
                chk("abort_done",  o_done(w8),  0);
                chk("abort_busy",  o_busy(w8),  0);
                chk("abort_data",  o_data(w8),  0);
                chk("abort_cnt",   o_cnt(w8),   intr_at);
                return;
            end
            if (intr_kind == 2 && idx == intr_at) begin
                #2 rst = 1'b1;
                #1 chk_all_zero(w8, "async_rst");
                #1 rst = 1'b0;
                out_ready = 1'b0;
                return;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = ($urandom_range(1, 0) == 1);
            endcase
            out_ready = rdy;
            // A start during RUN must leave the sequence untouched
            if (mode == 2 && $urandom_range(3, 0) == 0) begin
                if (w8) start8 = 1'b1; else start4 = 1'b1;
            end
            @(negedge clk);
            start4 = 1'b0;
            start8 = 1'b0;
            cyc++;
            if (rdy) idx++;
        end
        out_ready = 1'b0;
        chk("stream_complete", idx, n);
        chk("done",       o_done(w8),  1);
        chk("done_valid", o_valid(w8), 0);
        chk("done_busy",  o_busy(w8),  0);
        chk("done_cnt",   o_cnt(w8),   n);
        @(negedge clk);
        chk("done_hold",  o_done(w8),  1);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk_all_zero(1'b0, "reset4");
        chk_all_zero(1'b1, "reset8");
        @(negedge clk);
        rst = 1'b0;

        // T1/T2: N=4 with ready high, then ready toggling; the second start is issued in DONE
        run_stream(1'b0, 0, -1, 0);
        run_stream(1'b0, 1, -1, 0);
        // T3: N=8 ends 144,233
        run_stream(1'b1, 0, -1, 0);
        run_stream(1'b1, 2, -1, 0);
        // Random backpressure with stray starts during RUN
        for (int k = 0; k < 3; k++) run_stream(1'b0, 2, -1, 0);

        // T4: abort after 3 accepted terms, then restart at 0
        run_stream(1'b0, 0, 3, 1);
        run_stream(1'b0, 0, -1, 0);

        // T5: start and abort together in IDLE, after an abort that leaves the block idle
        run_stream(1'b0, 1, 2, 1);
        @(negedge clk);
        start4 = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        abort = 1'b0;
        chk("start_abort_valid", o_valid(1'b0), 0);
        chk("start_abort_busy",  o_busy(1'b0),  0);
        chk("start_abort_done",  o_done(1'b0),  0);
        @(negedge clk);
        chk("start_abort_hold",  o_busy(1'b0),  0);

        // T6: async reset at term 5, then a normal sequence
        run_stream(1'b0, 0, 5, 2);
        run_stream(1'b0, 0, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
